// File: rtl/uc_defs_pkg.sv
// Shared definitions for the LEGv8-subset multicycle control unit:
// state encodings, decode classes, opcode patterns/masks and bus codes.
package uc_defs;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CL_R   = 3'd0,
      CL_I   = 3'd1,
      CL_D   = 3'd2,
      CL_CB  = 3'd3,
      CL_ILL = 3'd4
   } iclass_t;

   localparam logic [2:0] ALU_AND    = 3'b000;
   localparam logic [2:0] ALU_ORR    = 3'b001;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_SUB    = 3'b011;
   localparam logic [2:0] ALU_PASS_B = 3'b100;

   localparam logic [1:0] SEU_I  = 2'b00;
   localparam logic [1:0] SEU_D  = 2'b01;
   localparam logic [1:0] SEU_CB = 2'b10;

   // Masks clear the don't-care low bits of the I and CB encodings
   localparam logic [10:0] MASK_FULL = 11'b11111111111;
   localparam logic [10:0] MASK_I    = 11'b11111111110;
   localparam logic [10:0] MASK_CB   = 11'b11111111000;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_ADDI = 11'b10010001000;
   localparam logic [10:0] OP_SUBI = 11'b11010001000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100000;
   localparam logic [10:0] OP_CBNZ = 11'b10110101000;

   function automatic logic op_match(input logic [10:0] op,
                                     input logic [10:0] pat,
                                     input logic [10:0] mask);
      return (op & mask) == pat;
   endfunction

endpackage

// File: rtl/decodificador_opcode.sv
// Combinational opcode classifier: instruction class plus the static
// ALU/immediate/writeback selects and branch sense for each opcode.
module decodificador_opcode
   import uc_defs::*;
(
   input  logic [10:0] opcode,
   output iclass_t     iclass,
   output logic [2:0]  alu_op,
   output logic [1:0]  seu,
   output logic        mem_to_reg,
   output logic        is_cbnz
);

   // Priority match of the opcode against each known encoding
   always_comb begin
      iclass     = CL_ILL;
      alu_op     = ALU_AND;
      seu        = SEU_I;
      mem_to_reg = 1'b0;
      is_cbnz    = 1'b0;
      if (op_match(opcode, OP_ADD, MASK_FULL)) begin
         iclass = CL_R;
         alu_op = ALU_ADD;
      end else if (op_match(opcode, OP_SUB, MASK_FULL)) begin
         iclass = CL_R;
         alu_op = ALU_SUB;
      end else if (op_match(opcode, OP_AND, MASK_FULL)) begin
         iclass = CL_R;
         alu_op = ALU_AND;
      end else if (op_match(opcode, OP_ORR, MASK_FULL)) begin
         iclass = CL_R;
         alu_op = ALU_ORR;
      end else if (op_match(opcode, OP_ADDI, MASK_I)) begin
         iclass = CL_I;
         alu_op = ALU_ADD;
      end else if (op_match(opcode, OP_SUBI, MASK_I)) begin
         iclass = CL_I;
         alu_op = ALU_SUB;
      end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
         iclass     = CL_D;
         alu_op     = ALU_ADD;
         seu        = SEU_D;
         mem_to_reg = 1'b1;
      end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
         iclass = CL_D;
         alu_op = ALU_ADD;
         seu    = SEU_D;
      end else if (op_match(opcode, OP_CBZ, MASK_CB)) begin
         iclass = CL_CB;
         alu_op = ALU_PASS_B;
         seu    = SEU_CB;
      end else if (op_match(opcode, OP_CBNZ, MASK_CB)) begin
         iclass  = CL_CB;
         alu_op  = ALU_PASS_B;
         seu     = SEU_CB;
         is_cbnz = 1'b1;
      end else begin
         iclass = CL_ILL;
      end
   end

endmodule

// File: rtl/unidad_control.sv
// Multicycle control FSM for the LEGv8-subset datapath: sequences IR/PC
// strobes and control buses, with single-step mode, trap and retire counter.
module unidad_control
   import uc_defs::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [10:0]      opcode,
   input  logic             step_en,
   input  logic             step,
   output logic             ir_en,
   output logic             pc_en,
   output logic             bus_reg2loc,
   output logic [1:0]       bus_seu,
   output logic             bus_aluSrc,
   output logic [2:0]       bus_aluOp,
   output logic             bus_memWr,
   output logic             bus_memToReg,
   output logic             bus_regWr,
   output logic             beq,
   output logic             bne,
   output logic             illegal,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   state_t     state_r;
   iclass_t    cls_r;
   logic       step_prev_r;

   iclass_t    dec_class_s;
   logic [2:0] dec_alu_op_s;
   logic [1:0] dec_seu_s;
   logic       dec_mem_to_reg_s;
   logic       dec_is_cbnz_s;
   logic       step_rise_s;

   decodificador_opcode u_dec (
      .opcode     (opcode),
      .iclass     (dec_class_s),
      .alu_op     (dec_alu_op_s),
      .seu        (dec_seu_s),
      .mem_to_reg (dec_mem_to_reg_s),
      .is_cbnz    (dec_is_cbnz_s)
   );

   assign step_rise_s = step & ~step_prev_r;
   assign state       = state_r;

   // Moore FSM: every output is computed for the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_FETCH;
         cls_r        <= CL_R;
         step_prev_r  <= 1'b0;
         ir_en        <= 1'b0;
         pc_en        <= 1'b0;
         bus_reg2loc  <= 1'b0;
         bus_seu      <= 2'b00;
         bus_aluSrc   <= 1'b0;
         bus_aluOp    <= 3'b000;
         bus_memWr    <= 1'b0;
         bus_memToReg <= 1'b0;
         bus_regWr    <= 1'b0;
         beq          <= 1'b0;
         bne          <= 1'b0;
         illegal      <= 1'b0;
         instr_count  <= {CNT_W{1'b0}};
      end else begin
         step_prev_r <= step;
         instr_count <= instr_count + {{(CNT_W-1){1'b0}}, pc_en};
         ir_en       <= 1'b0;
         pc_en       <= 1'b0;
         bus_memWr   <= 1'b0;
         bus_regWr   <= 1'b0;
         beq         <= 1'b0;
         bne         <= 1'b0;
         case (state_r)
            ST_FETCH: begin
               // ir_en low here means we are still waiting for permission
               if (ir_en) begin
                  state_r <= ST_DECODE;
               end else if (!step_en || step_rise_s) begin
                  ir_en <= 1'b1;
               end else begin
                  ir_en <= 1'b0;
               end
            end
            ST_DECODE: begin
               cls_r        <= dec_class_s;
               bus_aluOp    <= dec_alu_op_s;
               bus_seu      <= dec_seu_s;
               bus_memToReg <= dec_mem_to_reg_s;
               bus_reg2loc  <= (dec_class_s == CL_D) || (dec_class_s == CL_CB);
               bus_aluSrc   <= (dec_class_s == CL_D) || (dec_class_s == CL_I);
               if (dec_class_s == CL_ILL) begin
                  state_r <= ST_TRAP;
                  illegal <= 1'b1;
               end else begin
                  state_r <= ST_EXEC;
                  if (dec_class_s == CL_CB) begin
                     pc_en <= 1'b1;
                     beq   <= ~dec_is_cbnz_s;
                     bne   <= dec_is_cbnz_s;
                  end else begin
                     pc_en <= 1'b0;
                  end
               end
            end
            ST_EXEC: begin
               case (cls_r)
                  CL_CB: begin
                     state_r <= ST_FETCH;
                     ir_en   <= ~step_en;
                  end
                  CL_D: begin
                     state_r <= ST_MEM;
                     if (!bus_memToReg) begin
                        bus_memWr <= 1'b1;
                        pc_en     <= 1'b1;
                     end else begin
                        bus_memWr <= 1'b0;
                     end
                  end
                  default: begin
                     state_r   <= ST_WB;
                     bus_regWr <= 1'b1;
                     pc_en     <= 1'b1;
                  end
               endcase
            end
            ST_MEM: begin
               if (bus_memToReg) begin
                  state_r   <= ST_WB;
                  bus_regWr <= 1'b1;
                  pc_en     <= 1'b1;
               end else begin
                  state_r <= ST_FETCH;
                  ir_en   <= ~step_en;
               end
            end
            ST_WB: begin
               state_r <= ST_FETCH;
               ir_en   <= ~step_en;
            end
            ST_TRAP: begin
               state_r <= ST_TRAP;
               illegal <= 1'b1;
            end
            default: begin
               state_r <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unidad_control.sv
// Directed bench for unidad_control: per-opcode vector table plus
// hand-written trap, single-step and mid-instruction reset sequences.
module tb_unidad_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] opcode = 11'd0;
   logic        step_en = 1'b0;
   logic        step = 1'b0;
   logic        ir_en, pc_en, bus_reg2loc, bus_aluSrc, bus_memWr;
   logic        bus_memToReg, bus_regWr, beq, bne, illegal;
   logic [1:0]  bus_seu;
   logic [2:0]  bus_aluOp, state;
   logic [15:0] instr_count;

   int n_chk = 0;
   int n_fail = 0;

   unidad_control #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .step_en(step_en), .step(step),
      .ir_en(ir_en), .pc_en(pc_en), .bus_reg2loc(bus_reg2loc), .bus_seu(bus_seu),
      .bus_aluSrc(bus_aluSrc), .bus_aluOp(bus_aluOp), .bus_memWr(bus_memWr),
      .bus_memToReg(bus_memToReg), .bus_regWr(bus_regWr), .beq(beq), .bne(bne),
      .illegal(illegal), .state(state), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // care bits: [0] reg2loc, [1] seu, [2] aluSrc are checked only when set
   typedef struct {
      string       name;
      logic [10:0] op;
      int          cycles;
      logic [2:0]  alu_op;
      logic [1:0]  seu;
      logic        alu_src;
      logic        reg2loc;
      logic        mem2reg;
      logic        mw;
      logic        rw;
      logic        beq_e;
      logic        bne_e;
      logic [2:0]  care;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_ir(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (ir_en === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      bit          ok;
      int          cyc, npc, pc_cyc, nir;
      logic        mw, rw, sb, sn;
      logic [15:0] cnt0;

      vecs[0] = '{"ADD",  11'b10001011000, 4, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101};
      vecs[1] = '{"SUB",  11'b11001011000, 4, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101};
      vecs[2] = '{"AND",  11'b10001010000, 4, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101};
      vecs[3] = '{"ORR",  11'b10101010000, 4, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101};
      vecs[4] = '{"ADDI", 11'b10010001001, 4, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110};
      vecs[5] = '{"SUBI", 11'b11010001000, 4, 3'b011, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110};
      vecs[6] = '{"LDUR", 11'b11111000010, 5, 3'b010, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111};
      vecs[7] = '{"STUR", 11'b11111000000, 4, 3'b010, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111};
      vecs[8] = '{"CBNZ", 11'b10110101011, 3, 3'b100, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011};
      vecs[9] = '{"CBZ",  11'b10110100101, 3, 3'b100, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011};

      // reset values
      repeat (2) @(negedge clk);
      check("rst_outputs", 32'({state, illegal, ir_en, pc_en, bus_memWr, bus_regWr, beq, bne,
                                bus_reg2loc, bus_seu, bus_aluSrc, bus_aluOp, bus_memToReg}), 32'd0);
      check("rst_count", 32'(instr_count), 32'd0);
      rst_n = 1'b1;

      // table: one instruction per vector, opcode scrambled after DECODE
      foreach (vecs[i]) begin
         wait_ir(ok);
         check({vecs[i].name, "_fetch"}, 32'(ok), 32'd1);
         if (ok) begin
            opcode = vecs[i].op;
            cnt0 = instr_count;
            cyc = 0; npc = 0; pc_cyc = -1;
            mw = 1'b0; rw = 1'b0; sb = 1'b0; sn = 1'b0;
            do begin
               @(negedge clk);
               cyc++;
               if (cyc == 2) opcode = 11'd0;
               mw |= bus_memWr; rw |= bus_regWr; sb |= beq; sn |= bne;
               if (pc_en) begin
                  npc++;
                  pc_cyc = cyc;
               end
            end while (!ir_en && cyc < 12);
            check({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].cycles));
            check({vecs[i].name, "_aluOp"}, 32'(bus_aluOp), 32'(vecs[i].alu_op));
            check({vecs[i].name, "_memToReg"}, 32'(bus_memToReg), 32'(vecs[i].mem2reg));
            if (vecs[i].care[0]) check({vecs[i].name, "_reg2loc"}, 32'(bus_reg2loc), 32'(vecs[i].reg2loc));
            if (vecs[i].care[1]) check({vecs[i].name, "_seu"}, 32'(bus_seu), 32'(vecs[i].seu));
            if (vecs[i].care[2]) check({vecs[i].name, "_aluSrc"}, 32'(bus_aluSrc), 32'(vecs[i].alu_src));
            check({vecs[i].name, "_strobes"}, 32'({mw, rw, sb, sn}),
                  32'({vecs[i].mw, vecs[i].rw, vecs[i].beq_e, vecs[i].bne_e}));
            check({vecs[i].name, "_pc_pulses"}, 32'(npc), 32'd1);
            check({vecs[i].name, "_pc_cycle"}, 32'(pc_cyc), 32'(vecs[i].cycles - 1));
            check({vecs[i].name, "_count"}, 32'(instr_count), 32'(cnt0 + 16'd1));
         end
      end
      check("table_total_count", 32'(instr_count), 32'd10);

      // illegal opcode traps for good; only reset leaves
      do_reset();
      wait_ir(ok);
      check("trap_fetch", 32'(ok), 32'd1);
      opcode = 11'b00000000000;
      repeat (2) @(negedge clk);
      opcode = 11'b10001011000;
      for (int k = 0; k < 20; k++) begin
         check("trap_hold", 32'({state, illegal, ir_en, pc_en, bus_memWr, bus_regWr, beq, bne}),
               32'({3'd7, 1'b1, 6'b000000}));
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check("trap_reset", 32'({state, illegal}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // single-step: held step retires one instruction, a new edge the next
      step_en = 1'b1;
      do_reset();
      opcode = 11'b10001011000;
      @(negedge clk);
      step = 1'b1;
      nir = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (ir_en) nir++;
      end
      check("step_ir_pulses", 32'(nir), 32'd1);
      check("step_count1", 32'(instr_count), 32'd1);
      check("step_idle", 32'({state, ir_en}), 32'd0);
      step = 1'b0;
      @(negedge clk);
      step = 1'b1;
      repeat (10) @(negedge clk);
      check("step_count2", 32'(instr_count), 32'd2);
      step = 1'b0;
      step_en = 1'b0;

      // reset asserted during WB of SUBI
      do_reset();
      wait_ir(ok);
      check("wbrst_fetch", 32'(ok), 32'd1);
      opcode = 11'b11010001000;
      repeat (3) @(negedge clk);
      check("wbrst_in_wb", 32'({state, bus_regWr, pc_en}), 32'({3'd4, 1'b1, 1'b1}));
      rst_n = 1'b0;
      #1;
      check("wbrst_drop", 32'({state, bus_regWr, pc_en}), 32'd0);
      check("wbrst_count", 32'(instr_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ir(ok);
      check("wbrst_refetch", 32'(ok), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
